// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs : reservation station for ALU-class instructions.
//
// Holds up to ENTRIES dispatched instructions until both source operands are
// available, snooping the ALU and load/store result buses to capture values.
// Each cycle, the lowest-index slot whose operands are both valid is issued to
// the ALU through a set of registered ex* outputs.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ALUen ... ALUaddr        dispatch strobe and instruction fields
//   cdbAlu* / cdbLs*         result broadcasts (enable, tag, data)
//   rsFull                   every slot is occupied; dispatcher must stall
//   exEn                     one-cycle issue pulse
//   exOperandO/T, exOp,
//   exAddr, exTagW, exNameW  fields of the issued instruction (held when idle)
// ---------------------------------------------------------------------------
module alu_rs #(
    parameter int         ENTRIES  = 8,
    parameter logic [4:0] TAG_FREE = 5'b11111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ALUen,
    input  logic [31:0] ALUoperandO,
    input  logic [31:0] ALUoperandT,
    input  logic [4:0]  ALUtagO,
    input  logic [4:0]  ALUtagT,
    input  logic [4:0]  ALUtagW,
    input  logic [4:0]  ALUnameW,
    input  logic [5:0]  ALUop,
    input  logic [31:0] ALUaddr,
    input  logic        cdbAluEn,
    input  logic [4:0]  cdbAluTag,
    input  logic [31:0] cdbAluData,
    input  logic        cdbLsEn,
    input  logic [4:0]  cdbLsTag,
    input  logic [31:0] cdbLsData,
    output logic        rsFull,
    output logic        exEn,
    output logic [31:0] exOperandO,
    output logic [31:0] exOperandT,
    output logic [5:0]  exOp,
    output logic [31:0] exAddr,
    output logic [4:0]  exTagW,
    output logic [4:0]  exNameW
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Slot storage
    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [5:0]         op_q     [ENTRIES];
    logic [5:0]         op_d     [ENTRIES];
    logic [31:0]        addr_q   [ENTRIES];
    logic [31:0]        addr_d   [ENTRIES];
    logic [4:0]         tagw_q   [ENTRIES];
    logic [4:0]         tagw_d   [ENTRIES];
    logic [4:0]         namew_q  [ENTRIES];
    logic [4:0]         namew_d  [ENTRIES];
    logic [4:0]         tag_o_q  [ENTRIES];
    logic [4:0]         tag_o_d  [ENTRIES];
    logic [31:0]        data_o_q [ENTRIES];
    logic [31:0]        data_o_d [ENTRIES];
    logic [4:0]         tag_t_q  [ENTRIES];
    logic [4:0]         tag_t_d  [ENTRIES];
    logic [31:0]        data_t_q [ENTRIES];
    logic [31:0]        data_t_d [ENTRIES];

    // Issue registers
    logic        ex_en_q, ex_en_d;
    logic [31:0] ex_operand_o_q, ex_operand_o_d;
    logic [31:0] ex_operand_t_q, ex_operand_t_d;
    logic [5:0]  ex_op_q, ex_op_d;
    logic [31:0] ex_addr_q, ex_addr_d;
    logic [4:0]  ex_tagw_q, ex_tagw_d;
    logic [4:0]  ex_namew_q, ex_namew_d;

    // Selection results
    logic [ENTRIES-1:0] ready;
    logic               issue_found;
    logic [IDX_W-1:0]   issue_idx;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;

    // Resolve one operand against both result buses. A pending tag that
    // matches an active bus becomes TAG_FREE with the bus data; when both
    // buses carry the same tag the ALU bus is checked first and wins.
    function automatic logic [36:0] wake(
        input logic [4:0]  tag,
        input logic [31:0] data,
        input logic        alu_en,
        input logic [4:0]  alu_tag,
        input logic [31:0] alu_data,
        input logic        ls_en,
        input logic [4:0]  ls_tag,
        input logic [31:0] ls_data
    );
        logic [36:0] r;
        r = {tag, data};
        if (tag != TAG_FREE) begin
            if (alu_en && (alu_tag == tag)) begin
                r = {TAG_FREE, alu_data};
            end else if (ls_en && (ls_tag == tag)) begin
                r = {TAG_FREE, ls_data};
            end
        end
        return r;
    endfunction

    // Readiness and priority selection are judged on registered state only,
    // so a slot woken at an edge can issue at the following edge at the
    // earliest, and a slot being issued is still seen as busy for dispatch.
    always_comb begin
        ready       = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready[i] = busy_q[i] && (tag_o_q[i] == TAG_FREE) && (tag_t_q[i] == TAG_FREE);
            if (!issue_found && ready[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!free_found && !busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Next slot state: wakeup of pending operands, release of the issued
    // slot, and a dispatch write into the lowest free slot (with bypass from
    // the buses active in the same cycle). A dispatch while full is dropped.
    always_comb begin
        busy_d   = busy_q;
        op_d     = op_q;
        addr_d   = addr_q;
        tagw_d   = tagw_q;
        namew_d  = namew_q;
        tag_o_d  = tag_o_q;
        data_o_d = data_o_q;
        tag_t_d  = tag_t_q;
        data_t_d = data_t_q;

        for (int i = 0; i < ENTRIES; i++) begin
            if (busy_q[i]) begin
                {tag_o_d[i], data_o_d[i]} = wake(tag_o_q[i], data_o_q[i],
                    cdbAluEn, cdbAluTag, cdbAluData, cdbLsEn, cdbLsTag, cdbLsData);
                {tag_t_d[i], data_t_d[i]} = wake(tag_t_q[i], data_t_q[i],
                    cdbAluEn, cdbAluTag, cdbAluData, cdbLsEn, cdbLsTag, cdbLsData);
            end
        end

        if (issue_found) begin
            busy_d[issue_idx] = 1'b0;
        end

        if (ALUen && free_found) begin
            busy_d[free_idx]  = 1'b1;
            op_d[free_idx]    = ALUop;
            addr_d[free_idx]  = ALUaddr;
            tagw_d[free_idx]  = ALUtagW;
            namew_d[free_idx] = ALUnameW;
            {tag_o_d[free_idx], data_o_d[free_idx]} = wake(ALUtagO, ALUoperandO,
                cdbAluEn, cdbAluTag, cdbAluData, cdbLsEn, cdbLsTag, cdbLsData);
            {tag_t_d[free_idx], data_t_d[free_idx]} = wake(ALUtagT, ALUoperandT,
                cdbAluEn, cdbAluTag, cdbAluData, cdbLsEn, cdbLsTag, cdbLsData);
        end
    end

    // Issue registers load from the registered slot contents only; with no
    // ready slot the pulse drops and the data fields keep their last values.
    always_comb begin
        ex_en_d        = issue_found;
        ex_operand_o_d = ex_operand_o_q;
        ex_operand_t_d = ex_operand_t_q;
        ex_op_d        = ex_op_q;
        ex_addr_d      = ex_addr_q;
        ex_tagw_d      = ex_tagw_q;
        ex_namew_d     = ex_namew_q;
        if (issue_found) begin
            ex_operand_o_d = data_o_q[issue_idx];
            ex_operand_t_d = data_t_q[issue_idx];
            ex_op_d        = op_q[issue_idx];
            ex_addr_d      = addr_q[issue_idx];
            ex_tagw_d      = tagw_q[issue_idx];
            ex_namew_d     = namew_q[issue_idx];
        end
    end

    // Control state: reset discards every in-flight instruction and clears
    // the issue outputs, overriding whatever else happens in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            ex_en_q        <= 1'b0;
            ex_operand_o_q <= '0;
            ex_operand_t_q <= '0;
            ex_op_q        <= '0;
            ex_addr_q      <= '0;
            ex_tagw_q      <= TAG_FREE;
            ex_namew_q     <= '0;
        end else begin
            busy_q         <= busy_d;
            ex_en_q        <= ex_en_d;
            ex_operand_o_q <= ex_operand_o_d;
            ex_operand_t_q <= ex_operand_t_d;
            ex_op_q        <= ex_op_d;
            ex_addr_q      <= ex_addr_d;
            ex_tagw_q      <= ex_tagw_d;
            ex_namew_q     <= ex_namew_d;
        end
    end

    // Slot payload needs no reset: it is meaningless while the busy bit is
    // clear and is fully rewritten on dispatch.
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        addr_q   <= addr_d;
        tagw_q   <= tagw_d;
        namew_q  <= namew_d;
        tag_o_q  <= tag_o_d;
        data_o_q <= data_o_d;
        tag_t_q  <= tag_t_d;
        data_t_q <= data_t_d;
    end

    assign rsFull     = &busy_q;
    assign exEn       = ex_en_q;
    assign exOperandO = ex_operand_o_q;
    assign exOperandT = ex_operand_t_q;
    assign exOp       = ex_op_q;
    assign exAddr     = ex_addr_q;
    assign exTagW     = ex_tagw_q;
    assign exNameW    = ex_namew_q;

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter ENTRIES, default 8, number of reservation-station slots (power of two, ≥2).
REQ-002 Parameter TAG_FREE, default 5'b11111, tag encoding meaning "operand value already valid".
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ALUen  input  1  dispatch strobe for one ALU-class instruction this cycle.
REQ-006 ALUoperandO / ALUoperandT  input  32 each  operand values, meaningful when matching tag is TAG_FREE.
REQ-007 ALUtagO / ALUtagT  input  5 each  producer tags of the operands, TAG_FREE if value valid.
REQ-008 ALUtagW  input  5  destination tag of the instruction; ALUnameW  input  5  destination register name.
REQ-009 ALUop  input  6  opcode; ALUaddr  input  32  instruction address.
REQ-010 cdbAluEn / cdbAluTag / cdbAluData  input  1/5/32  ALU result broadcast.
REQ-011 cdbLsEn / cdbLsTag / cdbLsData  input  1/5/32  load/store result broadcast.
REQ-012 rsFull  output  1  high when every slot is occupied.
REQ-013 exEn  output  1  issue valid to ALU, one-cycle pulse per issued instruction.
REQ-014 exOperandO / exOperandT  output  32 each; exOp  output  6; exAddr  output  32; exTagW  output  5; exNameW  output  5  issued instruction fields.

Function
REQ-015 Each slot holds: busy, op, addr, tagW, nameW, two (tag, data) operand pairs.
REQ-016 ALUen high and at least one slot free: instruction written at the edge into the lowest-index free slot, busy set.
REQ-017 ALUen high while rsFull high: request dropped, no state change (dispatcher must stall; bench flags it as a protocol error).
REQ-018 Wakeup: every busy slot compares each operand tag against both CDBs each cycle; on match (enable high, tag ≠ TAG_FREE) data captured and tag set to TAG_FREE at the edge.
REQ-019 Dispatch bypass: incoming operand tag matching an active CDB tag in the same cycle is stored as TAG_FREE with CDB data.
REQ-020 Both CDBs carrying the same tag in one cycle: ALU CDB data wins.
REQ-021 Slot ready = busy and both operand tags TAG_FREE, judged on registered slot state.
REQ-022 Select: lowest-index ready slot; at the edge its fields load the ex* registers, exEn set, slot busy cleared.
REQ-023 No ready slot: exEn low at next edge; ex* data outputs hold previous values.
REQ-024 Latency: instruction dispatched with both operands valid at edge N issues at edge N+1 (exEn high in cycle N+1); operand woken at edge N → issue no earlier than edge N+1.
REQ-025 At most one dispatch and one issue per cycle; both may occur together, including into the slot freed by that issue only from the next cycle (freed slot not reused at same edge).
REQ-026 rsFull combinational from registered busy bits: high iff all ENTRIES busy.
REQ-027 Issued operand values reflect only registered data (no CDB forwarding straight to ex* outputs).

Reset
REQ-028 rst high at an edge: all busy bits cleared, exEn = 0, ex* data outputs = 0, exTagW = TAG_FREE, exNameW = 0; rsFull = 0 thereafter.
REQ-029 rst overrides dispatch, wakeup and issue in the same cycle; instructions in flight are discarded.

Verification
REQ-030 Ready dispatch: ALUen, tags TAG_FREE, operands 5/7, op ADD, tagW 3 at edge 0 -> exEn at edge 1 with exOperandO=5, exOperandT=7, exTagW=3; slot freed.
REQ-031 Wakeup: dispatch tagO=2 (pending), then cdbAluEn tag 2 data 0x1234 at edge 3 -> exEn at edge 4, exOperandO=0x1234.
REQ-032 Bypass: dispatch tagT=6 in same cycle as cdbLsEn tag 6 data 0xABCD -> issue next edge with exOperandT=0xABCD.
REQ-033 Fill: 8 dispatches with pending tags -> rsFull high after 8th edge; 9th ALUen ignored; one CDB wakeup -> one issue, rsFull low next cycle.
REQ-034 Ordering: slots 1 and 4 become ready at the same edge -> slot 1 issues first, slot 4 the following edge.
REQ-035 Reset mid-operation: rst with 3 busy slots and exEn high -> next cycle exEn=0, rsFull=0, no stale issue afterwards.
